// File: rtl/axi2mem_trans_arbiter.sv
// Burst-granular arbiter sharing the dual-lane axi2mem memory transaction port between read and write sequencers.
// Define AXI2MEM_ARB_RD_PRIO_EN for fixed read priority on ties; default build is round-robin.
module axi2mem_trans_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 6,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH/8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rd_pend_i,
   input  logic [1:0]              rd_trans_req_i,
   input  logic [2*ADDR_WIDTH-1:0] rd_trans_add_i,
   input  logic [2*ID_WIDTH-1:0]   rd_trans_id_i,
   input  logic [1:0]              rd_trans_last_i,
   output logic [1:0]              rd_trans_gnt_o,
   input  logic                    wr_pend_i,
   input  logic [1:0]              wr_trans_req_i,
   input  logic [2*ADDR_WIDTH-1:0] wr_trans_add_i,
   input  logic [2*ID_WIDTH-1:0]   wr_trans_id_i,
   input  logic [1:0]              wr_trans_last_i,
   input  logic [2*DATA_WIDTH-1:0] wr_trans_wdata_i,
   input  logic [2*BE_WIDTH-1:0]   wr_trans_be_i,
   output logic [1:0]              wr_trans_gnt_o,
   output logic [1:0]              mem_req_o,
   output logic                    mem_we_o,
   output logic [2*ADDR_WIDTH-1:0] mem_add_o,
   output logic [2*ID_WIDTH-1:0]   mem_id_o,
   output logic [1:0]              mem_last_o,
   output logic [2*DATA_WIDTH-1:0] mem_wdata_o,
   output logic [2*BE_WIDTH-1:0]   mem_be_o,
   input  logic [1:0]              mem_gnt_i,
   output logic [1:0]              owner_o
);

   // state  | meaning
   // IDLE   | no burst locked; selection from pend and tie-break
   // RD_OWN | read burst in progress, only rd selected
   // WR_OWN | write burst in progress, only wr selected
   typedef enum logic [1:0] {IDLE, RD_OWN, WR_OWN} state_e;

   state_e state_q, state_d;
   logic   sel_rd, sel_wr;
   logic   beat_acc, beat_last;

`ifndef AXI2MEM_ARB_RD_PRIO_EN
   // 1 = wr served last, so rd wins the first tie after reset
   logic rr_q, rr_d;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
`ifndef AXI2MEM_ARB_RD_PRIO_EN
         rr_q    <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
`ifndef AXI2MEM_ARB_RD_PRIO_EN
         rr_q    <= rr_d;
`endif
      end
   end

   always_comb begin
      sel_rd = 1'b0;
      sel_wr = 1'b0;
      case (state_q)
         RD_OWN: sel_rd = 1'b1;
         WR_OWN: sel_wr = 1'b1;
         default: begin
            if (rd_pend_i && wr_pend_i) begin
`ifdef AXI2MEM_ARB_RD_PRIO_EN
               sel_rd = 1'b1;
`else
               sel_rd = rr_q;
               sel_wr = ~rr_q;
`endif
            end else begin
               sel_rd = rd_pend_i;
               sel_wr = wr_pend_i;
            end
         end
      endcase
   end

   // Partial-lane requests are forwarded but never complete a beat
   always_comb begin
      beat_acc  = (mem_gnt_i == 2'b11) &&
                  ((sel_rd && rd_trans_req_i == 2'b11) ||
                   (sel_wr && wr_trans_req_i == 2'b11));
      beat_last = sel_wr ? (wr_trans_last_i == 2'b11) : (rd_trans_last_i == 2'b11);
   end

   always_comb begin
      state_d = state_q;
`ifndef AXI2MEM_ARB_RD_PRIO_EN
      rr_d    = rr_q;
`endif
      if (beat_acc) begin
         if (beat_last)   state_d = IDLE;
         else if (sel_wr) state_d = WR_OWN;
         else             state_d = RD_OWN;
`ifndef AXI2MEM_ARB_RD_PRIO_EN
         rr_d = sel_wr;
`endif
      end
   end

   always_comb begin
      rd_trans_gnt_o = mem_gnt_i & {2{sel_rd}};
      wr_trans_gnt_o = mem_gnt_i & {2{sel_wr}};
      owner_o        = {sel_wr, sel_rd};
      mem_req_o      = '0;
      mem_we_o       = 1'b0;
      mem_add_o      = '0;
      mem_id_o       = '0;
      mem_last_o     = '0;
      mem_wdata_o    = '0;
      mem_be_o       = '0;
      if (sel_wr) begin
         mem_req_o   = wr_trans_req_i;
         mem_we_o    = 1'b1;
         mem_add_o   = wr_trans_add_i;
         mem_id_o    = wr_trans_id_i;
         mem_last_o  = wr_trans_last_i;
         mem_wdata_o = wr_trans_wdata_i;
         mem_be_o    = wr_trans_be_i;
      end else if (sel_rd) begin
         mem_req_o   = rd_trans_req_i;
         mem_add_o   = rd_trans_add_i;
         mem_id_o    = rd_trans_id_i;
         mem_last_o  = rd_trans_last_i;
      end
   end

endmodule

// File: tb/tb_axi2mem_trans_arbiter.sv
// Directed self-checking bench for axi2mem_trans_arbiter; expectations follow AXI2MEM_ARB_RD_PRIO_EN when defined.
module tb_axi2mem_trans_arbiter;

`ifdef AXI2MEM_ARB_RD_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rd_pend_i, wr_pend_i;
   logic [1:0]  rd_trans_req_i, rd_trans_last_i, rd_trans_gnt_o;
   logic [63:0] rd_trans_add_i;
   logic [11:0] rd_trans_id_i;
   logic [1:0]  wr_trans_req_i, wr_trans_last_i, wr_trans_gnt_o;
   logic [63:0] wr_trans_add_i, wr_trans_wdata_i;
   logic [11:0] wr_trans_id_i;
   logic [7:0]  wr_trans_be_i;
   logic [1:0]  mem_req_o, mem_last_o, mem_gnt_i, owner_o;
   logic        mem_we_o;
   logic [63:0] mem_add_o, mem_wdata_o;
   logic [11:0] mem_id_o;
   logic [7:0]  mem_be_o;

   int n_chk  = 0;
   int n_fail = 0;

   axi2mem_trans_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_pend_i(rd_pend_i), .rd_trans_req_i(rd_trans_req_i), .rd_trans_add_i(rd_trans_add_i),
      .rd_trans_id_i(rd_trans_id_i), .rd_trans_last_i(rd_trans_last_i), .rd_trans_gnt_o(rd_trans_gnt_o),
      .wr_pend_i(wr_pend_i), .wr_trans_req_i(wr_trans_req_i), .wr_trans_add_i(wr_trans_add_i),
      .wr_trans_id_i(wr_trans_id_i), .wr_trans_last_i(wr_trans_last_i), .wr_trans_wdata_i(wr_trans_wdata_i),
      .wr_trans_be_i(wr_trans_be_i), .wr_trans_gnt_o(wr_trans_gnt_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_add_o(mem_add_o), .mem_id_o(mem_id_o),
      .mem_last_o(mem_last_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      rd_pend_i = 0; wr_pend_i = 0;
      rd_trans_req_i = 0; rd_trans_last_i = 0; rd_trans_add_i = 0; rd_trans_id_i = 0;
      wr_trans_req_i = 0; wr_trans_last_i = 0; wr_trans_add_i = 0; wr_trans_id_i = 0;
      wr_trans_wdata_i = 0; wr_trans_be_i = 0;
      mem_gnt_i = 2'b11;

      // reset, no pend
      #1;
      chk("rst_owner", owner_o, 2'b00);
      chk("rst_mem_req", mem_req_o, 2'b00);
      chk("rst_rd_gnt", rd_trans_gnt_o, 2'b00);
      chk("rst_mem_add", mem_add_o, 64'h0);
      // reset, both pend: rd wins first tie
      rd_pend_i = 1; wr_pend_i = 1;
      #1;
      chk("rst_tie_rd_gnt", rd_trans_gnt_o, 2'b11);
      chk("rst_tie_wr_gnt", wr_trans_gnt_o, 2'b00);
      chk("rst_tie_owner", owner_o, 2'b01);
      step();
      rst_i = 1'b0;

      // rd 4-beat burst with wr pending
      rd_trans_req_i = 2'b11;
      rd_trans_add_i = 64'h0000_0044_0000_0040;
      rd_trans_id_i  = 12'h145;
      for (int b = 1; b <= 4; b++) begin
         rd_trans_last_i = (b == 4) ? 2'b11 : 2'b00;
         #1;
         chk($sformatf("rdb%0d_wr_gnt", b), wr_trans_gnt_o, 2'b00);
         chk($sformatf("rdb%0d_owner", b), owner_o, 2'b01);
         chk($sformatf("rdb%0d_add", b), mem_add_o, 64'h0000_0044_0000_0040);
         step();
      end
      rd_trans_req_i = 0; rd_trans_last_i = 0;
      #1;
      chk("after_rd_owner", owner_o, PRIO ? 2'b01 : 2'b10);
      chk("after_rd_we", mem_we_o, PRIO ? 1'b0 : 1'b1);

      // wr burst with mem_gnt 11/01/11
      rd_pend_i = 0;
      wr_trans_req_i = 2'b11; wr_trans_last_i = 2'b00;
      #1;
      chk("wr1_owner", owner_o, 2'b10);
      step();
      rd_pend_i = 1;
      mem_gnt_i = 2'b01; wr_trans_last_i = 2'b11;
      #1;
      chk("wr2_wr_gnt", wr_trans_gnt_o, 2'b01);
      chk("wr2_rd_gnt", rd_trans_gnt_o, 2'b00);
      chk("wr2_owner", owner_o, 2'b10);
      step();
      mem_gnt_i = 2'b11;
      #1;
      chk("wr3_owner", owner_o, 2'b10);
      chk("wr3_rd_gnt", rd_trans_gnt_o, 2'b00);
      step();

      // alternating single-beat bursts, both pend held
      rd_trans_req_i = 2'b11; rd_trans_last_i = 2'b11;
      wr_trans_req_i = 2'b11; wr_trans_last_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("alt%0d_owner", i), owner_o, (PRIO || i % 2 == 0) ? 2'b01 : 2'b10);
         step();
      end

      // reset during beat 2 of a wr burst
      rd_pend_i = 0; rd_trans_req_i = 0; rd_trans_last_i = 0;
      wr_pend_i = 1; wr_trans_req_i = 2'b11; wr_trans_last_i = 2'b00;
      wr_trans_add_i   = 64'h0000_0104_0000_0100;
      wr_trans_id_i    = 12'h2A1;
      wr_trans_wdata_i = 64'hCAFE_F00D_DEAD_BEEF;
      wr_trans_be_i    = 8'h3F;
      #1;
      chk("wrr1_owner", owner_o, 2'b10);
      step();
      #1;
      chk("wrr2_owner", owner_o, 2'b10);
      rst_i = 1'b1; wr_pend_i = 0; wr_trans_req_i = 0;
      #1;
      chk("mrst_owner", owner_o, 2'b00);
      chk("mrst_mem_req", mem_req_o, 2'b00);
      chk("mrst_mem_we", mem_we_o, 1'b0);
      chk("mrst_mem_add", mem_add_o, 64'h0);
      chk("mrst_mem_wdata", mem_wdata_o, 64'h0);
      chk("mrst_mem_be", mem_be_o, 8'h0);
      step();
      rst_i = 1'b0;
      rd_pend_i = 1; rd_trans_req_i = 2'b11; rd_trans_last_i = 2'b11;
      rd_trans_add_i = 64'h0000_0204_0000_0200;
      #1;
      chk("post_rd_gnt", rd_trans_gnt_o, 2'b11);
      chk("post_wr_gnt", wr_trans_gnt_o, 2'b00);
      chk("post_owner", owner_o, 2'b01);
      chk("post_add", mem_add_o, 64'h0000_0204_0000_0200);
      chk("post_wdata_zero", mem_wdata_o, 64'h0);
      chk("post_be_zero", mem_be_o, 8'h0);
      step();

      // write beat pass-through
      rd_pend_i = 0; rd_trans_req_i = 0;
      wr_pend_i = 1; wr_trans_req_i = 2'b11; wr_trans_last_i = 2'b11;
      #1;
      chk("wd_we", mem_we_o, 1'b1);
      chk("wd_add_l0", mem_add_o[31:0], 32'h100);
      chk("wd_add_l1", mem_add_o[63:32], 32'h104);
      chk("wd_data_l0", mem_wdata_o[31:0], 32'hDEADBEEF);
      chk("wd_data_l1", mem_wdata_o[63:32], 32'hCAFEF00D);
      chk("wd_be_l0", mem_be_o[3:0], 4'hF);
      chk("wd_be_l1", mem_be_o[7:4], 4'h3);
      chk("wd_id", mem_id_o, 12'h2A1);
      chk("wd_req", mem_req_o, 2'b11);
      chk("wd_last", mem_last_o, 2'b11);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
